// File: rtl/qam_mod_pkg.sv
// Shared types and helpers for the QAM stream modulator.
//   tState        : packer FSM states.
//   gray2bin      : MaxM-bit gray to binary (zero-extended gray maps to zero-extended binary).
//   level         : PAM amplitude for axis index d with m bits per axis,
//                   (2d - (2**m - 1)) * 2**(dat_w-2) / 2**(m-1).
//   qam_supported : bits/symbol in {1,2,4,...,12} and not above the configured maximum.
package qam_mod_pkg;

  localparam int unsigned MaxM = 6;  // max bits per axis (12-bit symbols)

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } tState;

  function automatic logic [MaxM-1:0] gray2bin(input logic [MaxM-1:0] g);
    logic [MaxM-1:0] b;
    b[MaxM-1] = g[MaxM-1];
    for (int i = MaxM - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Scaling by P / 2**(m-1) is a left shift by dat_w-1-m; exact while dat_w >= MaxM+1.
  function automatic int level(input int m, input int d, input int dat_w);
    return (2 * d - (1 << m) + 1) <<< (dat_w - 1 - m);
  endfunction

  function automatic logic qam_supported(input logic [3:0] q, input int bmax);
    return ((q == 4'd1) || ((q[0] == 1'b0) && (q != 4'd0) && (q <= 4'd12))) &&
           (int'(q) <= bmax);
  endfunction

endpackage

// File: rtl/qam_axis_level.sv
// Combinational gray-coded axis bits to signed amplitude.
//   m_i     : bits per axis (1..6); bits of bits_i at and above m_i must be zero.
//   bits_i  : gray-coded axis bits, LSB aligned.
//   level_o : signed amplitude, pDAT_W bits, |level| < 2**(pDAT_W-1).
module qam_axis_level
  import qam_mod_pkg::*;
#(
  parameter int unsigned pDAT_W = 9
) (
  input  logic [2:0]        m_i,
  input  logic [MaxM-1:0]   bits_i,
  output logic [pDAT_W-1:0] level_o
);

  always_comb begin
    level_o = pDAT_W'(level(int'(m_i), int'(gray2bin(bits_i)), int'(pDAT_W)));
  end

endmodule

// File: rtl/qam_stream_modulator.sv
// Packs a framed bit stream (LSB first) into gray-coded QAM symbols with signed I/Q output.
//   iclk, ireset (async, active-low), iclkena (freezes everything when low)
//   Input word stream : ival/ordy handshake, isop/ieop framing, iqam (sampled on isop), idat
//   Symbol stream     : oval/iordy handshake, osop/oeop framing, oqam, oerr, odat_re/odat_im
module qam_stream_modulator
  import qam_mod_pkg::*;
#(
  parameter int unsigned pBMAX   = 12,
  parameter int unsigned pIDAT_W = 8,
  parameter int unsigned pDAT_W  = 9
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               isop,
  input  logic               ival,
  input  logic               ieop,
  input  logic [3:0]         iqam,
  input  logic [pIDAT_W-1:0] idat,
  output logic               ordy,
  input  logic               iordy,
  output logic               oval,
  output logic               osop,
  output logic               oeop,
  output logic [3:0]         oqam,
  output logic               oerr,
  output logic [pDAT_W-1:0]  odat_re,
  output logic [pDAT_W-1:0]  odat_im
);

  localparam int unsigned AccW = pBMAX + pIDAT_W;
  localparam int unsigned CntW = $clog2(AccW + 1);
  localparam int unsigned SymW = 2 * MaxM;

  localparam logic [pDAT_W-1:0] PosP = {2'b01, {(pDAT_W - 2){1'b0}}};
  localparam logic [pDAT_W-1:0] NegP = {2'b11, {(pDAT_W - 2){1'b0}}};

  tState             state_q, state_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        qam_q, qam_d;
  logic              sop_pend_q, sop_pend_d;
  logic              rdy_en_q;

  logic              oval_q, osop_q, oeop_q, oerr_q;
  logic [3:0]        oqam_q;
  logic [pDAT_W-1:0] re_q, im_q;

  logic              supported, flush, accept, can_emit, emit, last;
  logic [CntW-1:0]   nbits;
  logic [SymW-1:0]   sym;
  logic [2:0]        m;
  logic [MaxM-1:0]   mmask, re_bits, im_bits;
  logic [pDAT_W-1:0] lvl_re, lvl_im, re_nx, im_nx;

  // ordy depends on registered state only; rdy_en_q holds it low for the first cycle.
  assign ordy = rdy_en_q & (state_q != StFlush) & (cnt_q <= CntW'(pBMAX));

  // Handshake and symbol size decode.
  always_comb begin
    supported = qam_supported(qam_q, int'(pBMAX));
    // Unsupported sizes still need a consumption width so the frame drains.
    if (qam_q == 4'd0 || int'(qam_q) > int'(pBMAX)) begin
      nbits = CntW'(pBMAX);
    end else begin
      nbits = CntW'(qam_q);
    end
    flush    = (state_q == StFlush);
    accept   = iclkena & ival & ordy;
    can_emit = (cnt_q >= nbits) | (flush & (cnt_q != '0));
    emit     = iclkena & can_emit & (~oval_q | iordy);
    last     = flush & (cnt_q <= nbits);
  end

  // Packer and FSM next state: shift out the emitted symbol first, then append the new word.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    qam_d      = qam_q;
    sop_pend_d = sop_pend_q;

    if (emit) begin
      if (cnt_q >= nbits) begin
        acc_d = acc_q >> nbits;
        cnt_d = cnt_q - nbits;
      end else begin
        acc_d = '0;
        cnt_d = '0;
      end
      sop_pend_d = 1'b0;
      if (last) begin
        state_d = StIdle;
      end
    end else if (flush && cnt_q == '0) begin
      state_d = StIdle;
    end

    if (accept) begin
      if (isop) begin
        // New frame (or abort of the current one): restart from this word.
        acc_d      = AccW'(idat);
        cnt_d      = CntW'(pIDAT_W);
        qam_d      = iqam;
        sop_pend_d = 1'b1;
        state_d    = ieop ? StFlush : StRun;
      end else if (state_q == StRun) begin
        // Bits above cnt are always zero, so OR-in is a write at acc[cnt +: pIDAT_W].
        acc_d = acc_d | (AccW'(idat) << cnt_d);
        cnt_d = cnt_d + CntW'(pIDAT_W);
        if (ieop) begin
          state_d = StFlush;
        end
      end
    end
  end

  // Symbol to amplitude mapping; bits beyond cnt are zero, which pads the residue.
  always_comb begin
    sym     = SymW'(acc_q[pBMAX-1:0]);
    m       = qam_q[3:1];
    mmask   = ~({MaxM{1'b1}} << m);
    re_bits = sym[MaxM-1:0] & mmask;
    im_bits = MaxM'(sym >> m) & mmask;
    if (!supported) begin
      re_nx = '0;
      im_nx = '0;
    end else if (qam_q == 4'd1) begin
      re_nx = sym[0] ? PosP : NegP;
      im_nx = '0;
    end else begin
      re_nx = lvl_re;
      im_nx = lvl_im;
    end
  end

  qam_axis_level #(
    .pDAT_W (pDAT_W)
  ) u_level_re (
    .m_i     (m),
    .bits_i  (re_bits),
    .level_o (lvl_re)
  );

  qam_axis_level #(
    .pDAT_W (pDAT_W)
  ) u_level_im (
    .m_i     (m),
    .bits_i  (im_bits),
    .level_o (lvl_im)
  );

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      cnt_q      <= '0;
      qam_q      <= '0;
      sop_pend_q <= 1'b0;
      rdy_en_q   <= 1'b0;
      oval_q     <= 1'b0;
      osop_q     <= 1'b0;
      oeop_q     <= 1'b0;
      oqam_q     <= '0;
      oerr_q     <= 1'b0;
      re_q       <= '0;
      im_q       <= '0;
    end else if (iclkena) begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      qam_q      <= qam_d;
      sop_pend_q <= sop_pend_d;
      rdy_en_q   <= 1'b1;
      if (emit) begin
        oval_q <= 1'b1;
        osop_q <= sop_pend_q;
        oeop_q <= last;
        oqam_q <= qam_q;
        oerr_q <= ~supported;
        re_q   <= re_nx;
        im_q   <= im_nx;
      end else if (iordy) begin
        oval_q <= 1'b0;
      end
    end
  end

  assign oval    = oval_q;
  assign osop    = osop_q;
  assign oeop    = oeop_q;
  assign oqam    = oqam_q;
  assign oerr    = oerr_q;
  assign odat_re = re_q;
  assign odat_im = im_q;

endmodule

// File: tb/tb_qam_stream_modulator.sv
module tb_qam_stream_modulator;

  logic       iclk = 1'b0;
  logic       ireset, iclkena, isop, ival, ieop, iordy;
  logic [3:0] iqam;
  logic [7:0] idat;
  logic       ordy, oval, osop, oeop, oerr;
  logic [3:0] oqam;
  logic [8:0] odat_re, odat_im;

  typedef struct {
    int   re;
    int   im;
    logic sop;
    logic eop;
    logic err;
    int   qam;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   rx_cnt   = 0;
  logic seen_low = 1'b0;
  logic [7:0] wd;

  qam_stream_modulator #(
    .pBMAX   (12),
    .pIDAT_W (8),
    .pDAT_W  (9)
  ) dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .isop    (isop),
    .ival    (ival),
    .ieop    (ieop),
    .iqam    (iqam),
    .idat    (idat),
    .ordy    (ordy),
    .iordy   (iordy),
    .oval    (oval),
    .osop    (osop),
    .oeop    (oeop),
    .oqam    (oqam),
    .oerr    (oerr),
    .odat_re (odat_re),
    .odat_im (odat_im)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int re, input int im, input logic sop, input logic eop,
                      input logic err, input int q);
    exp_t e;
    e.re = re; e.im = im; e.sop = sop; e.eop = eop; e.err = err; e.qam = q;
    exp_q.push_back(e);
  endtask

  // 16QAM axis levels for P=128: gray 00,01,11,10 -> -192,-64,64,192.
  function automatic int lvl4(input logic [1:0] g);
    case (g)
      2'b00:   return -192;
      2'b01:   return -64;
      2'b11:   return 64;
      default: return 192;
    endcase
  endfunction

  // Drive one word and hold it until accepted; called at posedge+1.
  task automatic send_word(input logic sop, input logic eop, input logic [3:0] q,
                           input logic [7:0] d);
    int n;
    isop = sop; ieop = eop; iqam = q; idat = d; ival = 1'b1;
    n = 0;
    @(negedge iclk);
    while (!ordy && n < 200) begin
      @(negedge iclk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", int'(ordy), 1);
    @(posedge iclk);
    #1;
    ival = 1'b0; isop = 1'b0; ieop = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge iclk);
      n++;
    end
    chk({tag, "_drain"}, exp_q.size(), 0);
    @(posedge iclk);
    #1;
  endtask

  // Scoreboard: a symbol transfers at the posedge following a negedge with oval & iordy.
  always @(negedge iclk) begin
    if (ireset && iclkena && oval && iordy) begin
      rx_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_symbol", int'(oval), 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("re",  int'($signed(odat_re)), mon_e.re);
        chk("im",  int'($signed(odat_im)), mon_e.im);
        chk("sop", int'(osop), int'(mon_e.sop));
        chk("eop", int'(oeop), int'(mon_e.eop));
        chk("err", int'(oerr), int'(mon_e.err));
        chk("qam", int'(oqam), mon_e.qam);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ireset = 1'b0; iclkena = 1'b1; isop = 1'b0; ival = 1'b0; ieop = 1'b0;
    iqam = 4'd0; idat = 8'h00; iordy = 1'b1;

    // Reset state
    #3;
    chk("rst_ordy", int'(ordy), 0);
    chk("rst_oval", int'(oval), 0);
    chk("rst_re", int'(odat_re), 0);
    chk("rst_flags", int'({osop, oeop, oerr, oqam}), 0);
    repeat (2) @(negedge iclk);
    ireset = 1'b1;
    #1;
    chk("ordy_at_release", int'(ordy), 0);
    @(negedge iclk);
    chk("ordy_one_cycle_later", int'(ordy), 1);
    @(posedge iclk);
    #1;

    // 1: QPSK, one word isop+ieop
    push(-128, -128, 1'b1, 1'b0, 1'b0, 2);
    push( 128, -128, 1'b0, 1'b0, 1'b0, 2);
    push(-128,  128, 1'b0, 1'b0, 1'b0, 2);
    push( 128,  128, 1'b0, 1'b1, 1'b0, 2);
    send_word(1'b1, 1'b1, 4'd2, 8'hE4);
    drain("qpsk");

    // 2: 16QAM
    push(-64,   64, 1'b1, 1'b0, 1'b0, 4);
    push(192, -192, 1'b0, 1'b1, 1'b0, 4);
    send_word(1'b1, 1'b1, 4'd4, 8'h2D);
    drain("qam16");

    // 3: 4096QAM, second symbol spans words 2-3
    push(-252, -252, 1'b1, 1'b0, 1'b0, 12);
    push(-252, -252, 1'b0, 1'b1, 1'b0, 12);
    send_word(1'b1, 1'b0, 4'd12, 8'h00);
    send_word(1'b0, 1'b0, 4'd0, 8'h00);
    send_word(1'b0, 1'b1, 4'd0, 8'h00);
    drain("qam4096");

    // 4: 64QAM with zero-padded residue
    push( 96,   96, 1'b1, 1'b0, 1'b0, 6);
    push(-96, -224, 1'b0, 1'b1, 1'b0, 6);
    send_word(1'b1, 1'b1, 4'd6, 8'hFF);
    drain("qam64_residue");

    // Word without isop in IDLE is dropped
    rx_cnt = 0;
    send_word(1'b0, 1'b0, 4'd2, 8'hFF);
    repeat (10) @(negedge iclk);
    chk("dropped_word_rx", rx_cnt, 0);
    chk("dropped_word_oval", int'(oval), 0);
    @(posedge iclk);
    #1;

    // 5: 16 words of 16QAM with a 10-cycle downstream stall
    rx_cnt = 0;
    for (int w = 0; w < 16; w++) begin
      wd = 8'(w * 37 + 11);
      push(lvl4(wd[1:0]), lvl4(wd[3:2]), (w == 0), 1'b0, 1'b0, 4);
      push(lvl4(wd[5:4]), lvl4(wd[7:6]), 1'b0, (w == 15), 1'b0, 4);
    end
    fork
      begin
        for (int w = 0; w < 16; w++) begin
          send_word((w == 0), (w == 15), 4'd4, 8'(w * 37 + 11));
        end
      end
      begin
        repeat (6) @(posedge iclk);
        #1;
        iordy = 1'b0;
        for (int k = 0; k < 10; k++) begin
          @(negedge iclk);
          if (!ordy) seen_low = 1'b1;
        end
        @(posedge iclk);
        #1;
        iordy = 1'b1;
      end
    join
    drain("stream");
    chk("stream_count", rx_cnt, 32);
    chk("stream_ordy_dropped", int'(seen_low), 1);

    // 6a: asynchronous reset mid-frame while a symbol is held
    iordy = 1'b0;
    send_word(1'b1, 1'b0, 4'd2, 8'h00);
    repeat (3) @(negedge iclk);
    chk("held_oval", int'(oval), 1);
    chk("held_re", int'($signed(odat_re)), -128);
    #2;
    ireset = 1'b0;
    #1;
    chk("async_rst_oval", int'(oval), 0);
    chk("async_rst_re", int'(odat_re), 0);
    chk("async_rst_im", int'(odat_im), 0);
    chk("async_rst_ordy", int'(ordy), 0);
    repeat (2) @(negedge iclk);
    ireset = 1'b1;
    iordy  = 1'b1;
    @(posedge iclk);
    #1;

    // 6b: unsupported iqam=5
    push(0, 0, 1'b1, 1'b0, 1'b1, 5);
    push(0, 0, 1'b0, 1'b1, 1'b1, 5);
    send_word(1'b1, 1'b1, 4'd5, 8'hA5);
    drain("qam5_err");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
